// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer that drives every datapath strobe.
// Optional build macro CU_MEM_WAIT_EN adds mem_ready so memory cycles can stretch.
module control_unit #(
    parameter int OPW           = 5,
    parameter bit RESET_PC_LOAD = 1'b1
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           stop,
`ifdef CU_MEM_WAIT_EN
    input  logic           mem_ready,
`endif
    output logic [9:0]     bus_src,
    output logic [5:0]     reg_sel,
    output logic [10:0]    reg_ld,
    output logic [2:0]     mem,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic [5:0]     state_dbg
);

    typedef enum logic [5:0] {
        RESET, FETCH0, FETCH1, FETCH2, DECODE, HALT,
        ALU0, ALU1, ALU2,
        IMM0, IMM1, IMM2,
        LD0, LD1, LD2, LD3, LD4,
        ST0, ST1, ST2, ST3, ST4,
        MD0, MD1, MD2, MD3,
        BR0, BR1, BR2, BR3,
        JR0, JAL0, JAL1,
        IN0, OUT0, MFHI0, MFLO0
    } state_t;

    localparam int BUS_PC  = 9;
    localparam int BUS_MDR = 8;
    localparam int BUS_ZH  = 7;
    localparam int BUS_ZL  = 6;
    localparam int BUS_HI  = 5;
    localparam int BUS_LO  = 4;
    localparam int BUS_INP = 3;
    localparam int BUS_RC  = 2;

    localparam int SEL_GRA   = 5;
    localparam int SEL_GRB   = 4;
    localparam int SEL_GRC   = 3;
    localparam int SEL_RIN   = 2;
    localparam int SEL_ROUT  = 1;
    localparam int SEL_BAOUT = 0;

    localparam int LD_PC  = 10;
    localparam int LD_IR  = 9;
    localparam int LD_MAR = 8;
    localparam int LD_MDR = 7;
    localparam int LD_Y   = 6;
    localparam int LD_ZL  = 5;
    localparam int LD_ZH  = 4;
    localparam int LD_HI  = 3;
    localparam int LD_LO  = 2;
    localparam int LD_CON = 1;
    localparam int LD_OUT = 0;

    localparam int MEM_READ  = 2;
    localparam int MEM_WRITE = 1;
    localparam int MEM_INC   = 0;

    localparam logic [OPW-1:0] ALU_ADD = OPW'(3);

    typedef struct packed {
        logic [9:0]     bus_src;
        logic [5:0]     reg_sel;
        logic [10:0]    reg_ld;
        logic [2:0]     mem;
        logic [OPW-1:0] alu_op;
        logic           run;
    } ctl_t;

    state_t         state;
    state_t         next_state;
    state_t         boundary;
    state_t         first_exec;
    ctl_t           ctl_q;
    logic [OPW-1:0] opcode;
    logic [31:0]    op_val;
    logic           is_ldi;
    logic           mem_ok;
    logic           unused_ir;

    assign opcode    = ir[31 -: OPW];
    assign op_val    = 32'(opcode);
    assign is_ldi    = (op_val == 32'd1);
    assign unused_ir = ^ir[31-OPW:0];

    // mem_ready: the memory completes the access in a cycle where mem_ready=1;
    // until then the access state and all of its strobes are held unchanged.
`ifdef CU_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        boundary = stop ? HALT : FETCH0;

        if (op_val <= 32'd1)       first_exec = LD0;
        else if (op_val == 32'd2)  first_exec = ST0;
        else if (op_val <= 32'd11) first_exec = ALU0;
        else if (op_val <= 32'd14) first_exec = IMM0;
        else if (op_val <= 32'd16) first_exec = MD0;
        else if (op_val == 32'd18) first_exec = BR0;
        else if (op_val == 32'd19) first_exec = JR0;
        else if (op_val == 32'd20) first_exec = JAL0;
        else if (op_val == 32'd21) first_exec = IN0;
        else if (op_val == 32'd22) first_exec = OUT0;
        else if (op_val == 32'd23) first_exec = MFHI0;
        else if (op_val == 32'd24) first_exec = MFLO0;
        else if (op_val == 32'd26) first_exec = HALT;
        else                       first_exec = boundary;

        next_state = state;
        case (state)
            RESET:  next_state = FETCH0;
            FETCH0: next_state = FETCH1;
            FETCH1: next_state = mem_ok ? FETCH2 : FETCH1;
            FETCH2: next_state = DECODE;
            DECODE: next_state = first_exec;
            ALU0:   next_state = ALU1;
            ALU1:   next_state = ALU2;
            ALU2:   next_state = boundary;
            IMM0:   next_state = IMM1;
            IMM1:   next_state = IMM2;
            IMM2:   next_state = boundary;
            LD0:    next_state = LD1;
            LD1:    next_state = LD2;
            LD2:    next_state = is_ldi ? boundary : LD3;
            LD3:    next_state = mem_ok ? LD4 : LD3;
            LD4:    next_state = boundary;
            ST0:    next_state = ST1;
            ST1:    next_state = ST2;
            ST2:    next_state = ST3;
            ST3:    next_state = ST4;
            ST4:    next_state = mem_ok ? boundary : ST4;
            MD0:    next_state = MD1;
            MD1:    next_state = MD2;
            MD2:    next_state = MD3;
            MD3:    next_state = boundary;
            BR0:    next_state = BR1;
            BR1:    next_state = BR2;
            BR2:    next_state = BR3;
            BR3:    next_state = boundary;
            JR0:    next_state = boundary;
            JAL0:   next_state = JAL1;
            JAL1:   next_state = boundary;
            IN0:    next_state = boundary;
            OUT0:   next_state = boundary;
            MFHI0:  next_state = boundary;
            MFLO0:  next_state = boundary;
            HALT:   next_state = HALT;
            default: next_state = RESET;
        endcase
    end

    // Strobes for the state about to be entered, so they register alongside it.
    function automatic ctl_t strobes_for(input state_t s, input logic [OPW-1:0] op, input logic ldi);
        ctl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        c.run    = 1'b1;
        case (s)
            RESET:  c.reg_ld[LD_PC] = RESET_PC_LOAD;
            FETCH0: begin
                c.bus_src[BUS_PC] = 1'b1; c.reg_ld[LD_MAR] = 1'b1;
                c.mem[MEM_INC] = 1'b1;    c.reg_ld[LD_ZL] = 1'b1;
            end
            FETCH1: begin
                c.bus_src[BUS_ZL] = 1'b1; c.reg_ld[LD_PC] = 1'b1;
                c.mem[MEM_READ] = 1'b1;   c.reg_ld[LD_MDR] = 1'b1;
            end
            FETCH2: begin
                c.bus_src[BUS_MDR] = 1'b1; c.reg_ld[LD_IR] = 1'b1;
            end
            ALU0, MD0: begin
                c.reg_sel[(s == ALU0) ? SEL_GRB : SEL_GRA] = 1'b1;
                c.reg_sel[SEL_ROUT] = 1'b1; c.reg_ld[LD_Y] = 1'b1;
            end
            ALU1: begin
                c.reg_sel[SEL_GRC] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_ZL] = 1'b1;    c.alu_op = op;
            end
            IMM0, LD0, ST0: begin
                c.reg_sel[SEL_GRB] = 1'b1; c.reg_sel[SEL_BAOUT] = 1'b1;
                c.reg_ld[LD_Y] = 1'b1;
            end
            IMM1, LD1, ST1, BR2: begin
                c.bus_src[BUS_RC] = 1'b1; c.reg_ld[LD_ZL] = 1'b1;
                if (s == IMM1) c.alu_op = op;
            end
            ALU2, IMM2: begin
                c.bus_src[BUS_ZL] = 1'b1; c.reg_sel[SEL_GRA] = 1'b1;
                c.reg_sel[SEL_RIN] = 1'b1;
            end
            LD2: begin
                c.bus_src[BUS_ZL] = 1'b1;
                if (ldi) begin
                    c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_RIN] = 1'b1;
                end else begin
                    c.reg_ld[LD_MAR] = 1'b1;
                end
            end
            LD3: begin
                c.mem[MEM_READ] = 1'b1; c.reg_ld[LD_MDR] = 1'b1;
            end
            LD4: begin
                c.bus_src[BUS_MDR] = 1'b1; c.reg_sel[SEL_GRA] = 1'b1;
                c.reg_sel[SEL_RIN] = 1'b1;
            end
            ST2: begin
                c.bus_src[BUS_ZL] = 1'b1; c.reg_ld[LD_MAR] = 1'b1;
            end
            ST3: begin
                c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_MDR] = 1'b1;
            end
            ST4: c.mem[MEM_WRITE] = 1'b1;
            MD1: begin
                c.reg_sel[SEL_GRB] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_ZL] = 1'b1;    c.reg_ld[LD_ZH] = 1'b1;
                c.alu_op = op;
            end
            MD2: begin
                c.bus_src[BUS_ZL] = 1'b1; c.reg_ld[LD_LO] = 1'b1;
            end
            MD3: begin
                c.bus_src[BUS_ZH] = 1'b1; c.reg_ld[LD_HI] = 1'b1;
            end
            BR0: begin
                c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_CON] = 1'b1;
            end
            BR1: begin
                c.bus_src[BUS_PC] = 1'b1; c.reg_ld[LD_Y] = 1'b1;
            end
            BR3: c.bus_src[BUS_ZL] = 1'b1;
            JR0, JAL1: begin
                c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_PC] = 1'b1;
            end
            JAL0: begin
                c.bus_src[BUS_PC] = 1'b1; c.reg_sel[SEL_GRB] = 1'b1;
                c.reg_sel[SEL_RIN] = 1'b1;
            end
            IN0, MFHI0, MFLO0: begin
                c.bus_src[(s == IN0) ? BUS_INP : ((s == MFHI0) ? BUS_HI : BUS_LO)] = 1'b1;
                c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_RIN] = 1'b1;
            end
            OUT0: begin
                c.reg_sel[SEL_GRA] = 1'b1; c.reg_sel[SEL_ROUT] = 1'b1;
                c.reg_ld[LD_OUT] = 1'b1;
            end
            HALT:    c.run = 1'b0;
            default: c.run = 1'b1;
        endcase
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= RESET;
            ctl_q <= strobes_for(RESET, opcode, is_ldi);
        end else begin
            state <= next_state;
            ctl_q <= strobes_for(next_state, opcode, is_ldi);
        end
    end

    // The branch PC load follows con_ff live, since CON is loaded inside this instruction.
    assign bus_src   = ctl_q.bus_src;
    assign reg_sel   = ctl_q.reg_sel;
    assign reg_ld    = ctl_q.reg_ld | {((state == BR3) && con_ff), 10'b0};
    assign mem       = ctl_q.mem;
    assign alu_op    = ctl_q.alu_op;
    assign run       = ctl_q.run;
    assign state_dbg = state;

endmodule
